// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, ALU select codes, sequencer states and the control-word layout
// for the hardwired CPU control unit.
package cpu_ctrl_pkg;

   localparam int OP_W       = 5;
   localparam int ALU_CODE_W = 5;

   localparam logic [OP_W-1:0] OP_ADD  = 5'h00;
   localparam logic [OP_W-1:0] OP_SUB  = 5'h01;
   localparam logic [OP_W-1:0] OP_AND  = 5'h02;
   localparam logic [OP_W-1:0] OP_NOT  = 5'h03;
   localparam logic [OP_W-1:0] OP_OR   = 5'h04;
   localparam logic [OP_W-1:0] OP_NEG  = 5'h05;
   localparam logic [OP_W-1:0] OP_SHL  = 5'h06;
   localparam logic [OP_W-1:0] OP_SHR  = 5'h07;
   localparam logic [OP_W-1:0] OP_ADDI = 5'h08;
   localparam logic [OP_W-1:0] OP_ANDI = 5'h09;
   localparam logic [OP_W-1:0] OP_ORI  = 5'h0A;
   localparam logic [OP_W-1:0] OP_MUL  = 5'h0B;
   localparam logic [OP_W-1:0] OP_DIV  = 5'h0C;
   localparam logic [OP_W-1:0] OP_NOP  = 5'h1E;
   localparam logic [OP_W-1:0] OP_HALT = 5'h1F;

   localparam logic [ALU_CODE_W-1:0] ALU_NOP = 5'd0;
   localparam logic [ALU_CODE_W-1:0] ALU_ADD = 5'd1;
   localparam logic [ALU_CODE_W-1:0] ALU_SUB = 5'd2;
   localparam logic [ALU_CODE_W-1:0] ALU_AND = 5'd3;
   localparam logic [ALU_CODE_W-1:0] ALU_OR  = 5'd4;
   localparam logic [ALU_CODE_W-1:0] ALU_SHL = 5'd5;
   localparam logic [ALU_CODE_W-1:0] ALU_SHR = 5'd6;
   localparam logic [ALU_CODE_W-1:0] ALU_MUL = 5'd7;
   localparam logic [ALU_CODE_W-1:0] ALU_DIV = 5'd8;
   localparam logic [ALU_CODE_W-1:0] ALU_NOT = 5'd9;
   localparam logic [ALU_CODE_W-1:0] ALU_NEG = 5'd10;

   typedef enum logic [3:0] {
      IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, HALTED
   } state_t;

   typedef enum logic [2:0] {
      CLS_REG, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_BAD
   } op_class_t;

   typedef struct packed {
      logic                  pc_out;
      logic                  zhi_out;
      logic                  zlo_out;
      logic                  mdr_out;
      logic                  c_out;
      logic                  mar_in;
      logic                  z_in;
      logic                  pc_in;
      logic                  mdr_in;
      logic                  ir_in;
      logic                  y_in;
      logic                  hi_in;
      logic                  lo_in;
      logic                  inc_pc;
      logic                  read;
      logic                  gra;
      logic                  grb;
      logic                  grc;
      logic                  r_in;
      logic                  r_out;
      logic                  run;
      logic                  done;
      logic [ALU_CODE_W-1:0] alu_op;
   } ctrl_word_t;

   function automatic op_class_t op_class(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR: op_class = CLS_REG;
         OP_ADDI, OP_ANDI, OP_ORI:                      op_class = CLS_IMM;
         OP_NOT, OP_NEG:                                op_class = CLS_UNARY;
         OP_MUL, OP_DIV:                                op_class = CLS_MULDIV;
         OP_NOP:                                        op_class = CLS_NOP;
         OP_HALT:                                       op_class = CLS_HALT;
         default:                                       op_class = CLS_BAD;
      endcase
   endfunction

   function automatic logic [ALU_CODE_W-1:0] alu_code(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_ADDI: alu_code = ALU_ADD;
         OP_SUB:          alu_code = ALU_SUB;
         OP_AND, OP_ANDI: alu_code = ALU_AND;
         OP_OR, OP_ORI:   alu_code = ALU_OR;
         OP_SHL:          alu_code = ALU_SHL;
         OP_SHR:          alu_code = ALU_SHR;
         OP_MUL:          alu_code = ALU_MUL;
         OP_DIV:          alu_code = ALU_DIV;
         OP_NOT:          alu_code = ALU_NOT;
         OP_NEG:          alu_code = ALU_NEG;
         default:         alu_code = ALU_NOP;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode: sequencer state plus opcode -> datapath control word.
// In T3 the opcode comes straight from IR; later steps use the latched copy.
module ctrl_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int OPW = 5
) (
   input  state_t           state,
   input  logic [OPW-1:0]   op_q,
   input  logic [OPW-1:0]   ir_op,
   output ctrl_word_t       cw
);

   logic [OP_W-1:0] op;
   op_class_t       cls;

   always_comb begin
      op        = (state == T3) ? OP_W'(ir_op) : OP_W'(op_q);
      cls       = op_class(op);
      cw        = '0;
      cw.alu_op = ALU_NOP;
      cw.run    = (state != IDLE) && (state != HALTED);
      case (state)
         T0: begin
            cw.pc_out = 1'b1; cw.mar_in = 1'b1; cw.inc_pc = 1'b1;
            cw.z_in   = 1'b1; cw.alu_op = ALU_ADD;
         end
         T1: begin
            cw.zlo_out = 1'b1; cw.pc_in = 1'b1; cw.read = 1'b1; cw.mdr_in = 1'b1;
         end
         T1W: begin
            cw.read = 1'b1; cw.mdr_in = 1'b1;
         end
         T2: begin
            cw.mdr_out = 1'b1; cw.ir_in = 1'b1;
         end
         T3: begin
            case (cls)
               CLS_REG, CLS_IMM, CLS_MULDIV: begin
                  cw.grb = 1'b1; cw.r_out = 1'b1; cw.y_in = 1'b1;
               end
               CLS_UNARY: begin
                  cw.grb = 1'b1; cw.r_out = 1'b1; cw.z_in = 1'b1; cw.alu_op = alu_code(op);
               end
               CLS_NOP, CLS_HALT: cw.done = 1'b1;
               default: ;
            endcase
         end
         T4: begin
            cw.z_in   = 1'b1;
            cw.alu_op = alu_code(op);
            if (cls == CLS_IMM) begin
               cw.c_out = 1'b1;
            end else begin
               cw.grc = 1'b1; cw.r_out = 1'b1;
            end
         end
         T5: begin
            cw.zlo_out = 1'b1;
            if (cls == CLS_MULDIV) begin
               cw.lo_in = 1'b1;
            end else begin
               cw.gra = 1'b1; cw.r_in = 1'b1; cw.done = 1'b1;
            end
         end
         T6: begin
            cw.zhi_out = 1'b1; cw.hi_in = 1'b1; cw.done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/execute sequencer for the bus-based CPU datapath.
// Define CTRL_MEM_WAIT_EN to stretch the fetch read until Mem_ready (with timeout).
module ctrl_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int OPW         = 5,
   parameter int ALUW        = 5,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             Start,
   input  logic             Mem_ready,
   input  logic [OPW-1:0]   IR_op,
   output logic             PCout,
   output logic             Zhiout,
   output logic             Zlowout,
   output logic             MDRout,
   output logic             Cout,
   output logic             MARin,
   output logic             Zin,
   output logic             PCin,
   output logic             MDRin,
   output logic             IRin,
   output logic             Yin,
   output logic             HIin,
   output logic             LOin,
   output logic             IncPC,
   output logic             Read,
   output logic             Gra,
   output logic             Grb,
   output logic             Grc,
   output logic             Rin,
   output logic             Rout,
   output logic [ALUW-1:0]  alu_op,
   output logic             Run,
   output logic             Done,
   output logic             Illegal,
   output logic [3:0]       dbg_state
);

   state_t         state_q, state_d;
   logic [OPW-1:0] op_q, op_d;
   logic           illegal_q, illegal_d;
   ctrl_word_t     cw;

`ifdef CTRL_MEM_WAIT_EN
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
   localparam int unused_mem_timeout = MEM_TIMEOUT;
   logic unused_mem_ready;
   assign unused_mem_ready = Mem_ready;
`endif

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      illegal_d = illegal_q;
`ifdef CTRL_MEM_WAIT_EN
      wait_cnt_d = wait_cnt_q;
`endif
      case (state_q)
         IDLE:   if (Start) state_d = T0;
         HALTED: if (Start) begin state_d = T0; illegal_d = 1'b0; end
         T0:     state_d = T1;
`ifdef CTRL_MEM_WAIT_EN
         // Mem_ready is a level qualifier: read data is taken on the first edge it is high.
         T1: begin
            if (Mem_ready) state_d = T2;
            else begin state_d = T1W; wait_cnt_d = '0; end
         end
         T1W: begin
            if (Mem_ready) state_d = T2;
            else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
               state_d = HALTED; illegal_d = 1'b1;
            end else wait_cnt_d = wait_cnt_q + 1'b1;
         end
`else
         T1:     state_d = T2;
`endif
         T2:     state_d = T3;
         T3: begin
            op_d = IR_op;
            case (op_class(OP_W'(IR_op)))
               CLS_REG, CLS_IMM, CLS_MULDIV: state_d = T4;
               CLS_UNARY: state_d = T5;
               CLS_NOP:   state_d = T0;
               CLS_HALT:  state_d = HALTED;
               default: begin state_d = HALTED; illegal_d = 1'b1; end
            endcase
         end
         T4:     state_d = T5;
         T5:     state_d = (op_class(OP_W'(op_q)) == CLS_MULDIV) ? T6 : T0;
         T6:     state_d = T0;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Clear) begin
         state_q   <= IDLE;
         op_q      <= '0;
         illegal_q <= 1'b0;
`ifdef CTRL_MEM_WAIT_EN
         wait_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         illegal_q <= illegal_d;
`ifdef CTRL_MEM_WAIT_EN
         wait_cnt_q <= wait_cnt_d;
`endif
      end
   end

   ctrl_decode #(.OPW(OPW)) u_decode (
      .state (state_q),
      .op_q  (op_q),
      .ir_op (IR_op),
      .cw    (cw)
   );

   assign PCout     = cw.pc_out;
   assign Zhiout    = cw.zhi_out;
   assign Zlowout   = cw.zlo_out;
   assign MDRout    = cw.mdr_out;
   assign Cout      = cw.c_out;
   assign MARin     = cw.mar_in;
   assign Zin       = cw.z_in;
   assign PCin      = cw.pc_in;
   assign MDRin     = cw.mdr_in;
   assign IRin      = cw.ir_in;
   assign Yin       = cw.y_in;
   assign HIin      = cw.hi_in;
   assign LOin      = cw.lo_in;
   assign IncPC     = cw.inc_pc;
   assign Read      = cw.read;
   assign Gra       = cw.gra;
   assign Grb       = cw.grb;
   assign Grc       = cw.grc;
   assign Rin       = cw.r_in;
   assign Rout      = cw.r_out;
   assign alu_op    = ALUW'(cw.alu_op);
   assign Run       = cw.run;
   assign Done      = cw.done;
   assign Illegal   = illegal_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: the driver queues one expected control
// snapshot per clock, a negedge monitor pops and compares. Build with CTRL_MEM_WAIT_EN for wait-state cases.
module tb_ctrl_sequencer;
   import cpu_ctrl_pkg::*;

   localparam logic [19:0] S_PCOUT  = 20'h80000, S_ZHIOUT = 20'h40000, S_ZLOOUT = 20'h20000;
   localparam logic [19:0] S_MDROUT = 20'h10000, S_COUT   = 20'h08000, S_MARIN  = 20'h04000;
   localparam logic [19:0] S_ZIN    = 20'h02000, S_PCIN   = 20'h01000, S_MDRIN  = 20'h00800;
   localparam logic [19:0] S_IRIN   = 20'h00400, S_YIN    = 20'h00200, S_HIIN   = 20'h00100;
   localparam logic [19:0] S_LOIN   = 20'h00080, S_INCPC  = 20'h00040, S_READ   = 20'h00020;
   localparam logic [19:0] S_GRA    = 20'h00010, S_GRB    = 20'h00008, S_GRC    = 20'h00004;
   localparam logic [19:0] S_RIN    = 20'h00002, S_ROUT   = 20'h00001;

   logic       clk = 1'b0;
   logic       clear, start, mem_ready;
   logic [4:0] ir_op;
   logic       pc_out, zhi_out, zlo_out, mdr_out, c_out, mar_in, z_in, pc_in, mdr_in, ir_in;
   logic       y_in, hi_in, lo_in, inc_pc, read, gra, grb, grc, r_in, r_out;
   logic [4:0] alu_op;
   logic       run, done, illegal;
   logic [3:0] dbg_state;
   logic [31:0] act;

   logic [31:0] exp_q[$];
   string       tag_q[$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   ctrl_sequencer dut (
      .Clock(clk), .Clear(clear), .Start(start), .Mem_ready(mem_ready), .IR_op(ir_op),
      .PCout(pc_out), .Zhiout(zhi_out), .Zlowout(zlo_out), .MDRout(mdr_out), .Cout(c_out),
      .MARin(mar_in), .Zin(z_in), .PCin(pc_in), .MDRin(mdr_in), .IRin(ir_in), .Yin(y_in),
      .HIin(hi_in), .LOin(lo_in), .IncPC(inc_pc), .Read(read), .Gra(gra), .Grb(grb),
      .Grc(grc), .Rin(r_in), .Rout(r_out), .alu_op(alu_op), .Run(run), .Done(done),
      .Illegal(illegal), .dbg_state(dbg_state)
   );

   assign act = {dbg_state, run, done, illegal, alu_op,
                 pc_out, zhi_out, zlo_out, mdr_out, c_out, mar_in, z_in, pc_in, mdr_in, ir_in,
                 y_in, hi_in, lo_in, inc_pc, read, gra, grb, grc, r_in, r_out};

   function automatic logic [31:0] snap(input logic [3:0] st, input logic [19:0] strobes,
                                        input logic [4:0] alu, input logic r, input logic d,
                                        input logic il);
      return {st, r, d, il, alu, strobes};
   endfunction

   // Monitor: one comparison per clock whenever an expectation is pending.
   always @(negedge clk) begin
      logic [31:0] e;
      string       t;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", t, act, e);
         end
      end
   end

   task automatic cyc(input logic [31:0] e, input string tag);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input string tag);
      cyc(snap(T0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, ALU_ADD, 1, 0, 0), {tag, "_t0"});
      start = 1'b0;
      cyc(snap(T1, S_ZLOOUT | S_PCIN | S_READ | S_MDRIN, ALU_NOP, 1, 0, 0), {tag, "_t1"});
      cyc(snap(T2, S_MDROUT | S_IRIN, ALU_NOP, 1, 0, 0), {tag, "_t2"});
   endtask

   initial begin
      clear = 1'b1; start = 1'b0; mem_ready = 1'b1; ir_op = OP_NOT;
      cyc(snap(IDLE, 20'h0, ALU_NOP, 0, 0, 0), "reset0");
      start = 1'b1;
      cyc(snap(IDLE, 20'h0, ALU_NOP, 0, 0, 0), "reset_over_start");
      clear = 1'b0; start = 1'b0;
      cyc(snap(IDLE, 20'h0, ALU_NOP, 0, 0, 0), "idle_hold");

      // NOT R5,R2: 5-cycle instruction, Done in T5
      start = 1'b1;
      fetch("not");
      cyc(snap(T3, S_GRB | S_ROUT | S_ZIN, ALU_NOT, 1, 0, 0), "not_t3");
      cyc(snap(T5, S_ZLOOUT | S_GRA | S_RIN, ALU_NOP, 1, 1, 0), "not_t5");

      // ADD, with a stray Start during T4 that must be ignored
      ir_op = OP_ADD;
      fetch("add");
      cyc(snap(T3, S_GRB | S_ROUT | S_YIN, ALU_NOP, 1, 0, 0), "add_t3");
      cyc(snap(T4, S_GRC | S_ROUT | S_ZIN, ALU_ADD, 1, 0, 0), "add_t4");
      start = 1'b1;
      cyc(snap(T5, S_ZLOOUT | S_GRA | S_RIN, ALU_NOP, 1, 1, 0), "add_t5");
      start = 1'b0;

      // MUL: LO at T5, HI and Done at T6
      ir_op = OP_MUL;
      fetch("mul");
      cyc(snap(T3, S_GRB | S_ROUT | S_YIN, ALU_NOP, 1, 0, 0), "mul_t3");
      cyc(snap(T4, S_GRC | S_ROUT | S_ZIN, ALU_MUL, 1, 0, 0), "mul_t4");
      cyc(snap(T5, S_ZLOOUT | S_LOIN, ALU_NOP, 1, 0, 0), "mul_t5");
      cyc(snap(T6, S_ZHIOUT | S_HIIN, ALU_NOP, 1, 1, 0), "mul_t6");

      // ORI: immediate path drives C onto the bus in T4
      ir_op = OP_ORI;
      fetch("ori");
      cyc(snap(T3, S_GRB | S_ROUT | S_YIN, ALU_NOP, 1, 0, 0), "ori_t3");
      cyc(snap(T4, S_COUT | S_ZIN, ALU_OR, 1, 0, 0), "ori_t4");
      cyc(snap(T5, S_ZLOOUT | S_GRA | S_RIN, ALU_NOP, 1, 1, 0), "ori_t5");

      // HALT: Done in T3, then parked for 20 cycles until Start
      ir_op = OP_HALT;
      fetch("halt");
      cyc(snap(T3, 20'h0, ALU_NOP, 1, 1, 0), "halt_t3");
      for (int i = 0; i < 20; i++) cyc(snap(HALTED, 20'h0, ALU_NOP, 0, 0, 0), "halted");

      // Undefined opcode 0x15: Illegal, HALTED, no register write
      ir_op = 5'h15;
      start = 1'b1;
      fetch("bad");
      cyc(snap(T3, 20'h0, ALU_NOP, 1, 0, 0), "bad_t3");
      for (int i = 0; i < 3; i++) cyc(snap(HALTED, 20'h0, ALU_NOP, 0, 0, 1), "bad_halted");
      clear = 1'b1;
      cyc(snap(IDLE, 20'h0, ALU_NOP, 0, 0, 0), "bad_clear");
      clear = 1'b0;

      // Clear in T4 of an ADD aborts straight to IDLE
      ir_op = OP_ADD;
      start = 1'b1;
      fetch("abort");
      cyc(snap(T3, S_GRB | S_ROUT | S_YIN, ALU_NOP, 1, 0, 0), "abort_t3");
      cyc(snap(T4, S_GRC | S_ROUT | S_ZIN, ALU_ADD, 1, 0, 0), "abort_t4");
      clear = 1'b1;
      cyc(snap(IDLE, 20'h0, ALU_NOP, 0, 0, 0), "abort_idle");
      clear = 1'b0;
      cyc(snap(IDLE, 20'h0, ALU_NOP, 0, 0, 0), "abort_idle_hold");

      // Resume with NOP: 4 cycles, Done in T3, straight into the next fetch
      ir_op = OP_NOP;
      start = 1'b1;
      fetch("nop");
      cyc(snap(T3, 20'h0, ALU_NOP, 1, 1, 0), "nop_t3");
      cyc(snap(T0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, ALU_ADD, 1, 0, 0), "nop_next_t0");

`ifdef CTRL_MEM_WAIT_EN
      // Three low Mem_ready cycles: one T1 then three T1W, PCin only in T1
      mem_ready = 1'b0;
      cyc(snap(T1, S_ZLOOUT | S_PCIN | S_READ | S_MDRIN, ALU_NOP, 1, 0, 0), "wait_t1");
      for (int i = 0; i < 3; i++) cyc(snap(T1W, S_READ | S_MDRIN, ALU_NOP, 1, 0, 0), "wait_t1w");
      mem_ready = 1'b1;
      cyc(snap(T2, S_MDROUT | S_IRIN, ALU_NOP, 1, 0, 0), "wait_t2");
      cyc(snap(T3, 20'h0, ALU_NOP, 1, 1, 0), "wait_t3");
      cyc(snap(T0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, ALU_ADD, 1, 0, 0), "tmo_t0");
      // Mem_ready never arrives: 15 T1W cycles, then Illegal
      mem_ready = 1'b0;
      cyc(snap(T1, S_ZLOOUT | S_PCIN | S_READ | S_MDRIN, ALU_NOP, 1, 0, 0), "tmo_t1");
      for (int i = 0; i < 15; i++) cyc(snap(T1W, S_READ | S_MDRIN, ALU_NOP, 1, 0, 0), "tmo_t1w");
      cyc(snap(HALTED, 20'h0, ALU_NOP, 0, 0, 1), "tmo_halted");
      mem_ready = 1'b1;
`endif

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
